// File: rtl/control_dest_tracker_pkg.sv
// Shared types and constants for the destination tracker.
// A dest_t is the {rd, regwrite, memread} triple carried down the pipe.
package control_dest_tracker_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } dest_t;

    localparam dest_t BUBBLE = '{
        rd:       REG_ZERO,
        regwrite: 1'b0,
        memread:  1'b0
    };

    // x0 is never a real write target, so drop regwrite for it here.
    function automatic dest_t capture(
        input logic [REG_W-1:0] rd,
        input logic             regwrite,
        input logic             memread
    );
        dest_t d;
        d.rd       = rd;
        d.regwrite = regwrite & (rd != REG_ZERO);
        d.memread  = memread;
        return d;
    endfunction

endpackage

// File: rtl/ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Synchronous active-low reset.
module ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/control_dest_tracker.sv
// Carries rd/regwrite/memread through EX, MEM and WB, detects load-use
// hazards, freezes on data-cache misses and counts stall cycles.
module control_dest_tracker
    import control_dest_tracker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             dcache_stall,
    output logic             stall_ifid,
    output logic [REG_W-1:0] idex_rd,
    output logic             idex_regwrite,
    output logic             idex_memread,
    output logic [REG_W-1:0] exmem_rd,
    output logic             exmem_regwrite,
    output logic [REG_W-1:0] memwb_rd,
    output logic             memwb_regwrite,
    output logic [CNT_W-1:0] luse_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    dest_t idex;
    dest_t exmem;
    dest_t memwb;

    logic hit_rs1;
    logic hit_rs2;
    logic luse;
    logic luse_inc;
    logic miss_inc;

    assign hit_rs1 = ifid_use_rs1 & (ifid_rs1 == idex.rd);
    assign hit_rs2 = ifid_use_rs2 & (ifid_rs2 == idex.rd);
    assign luse    = idex.memread & (idex.rd != REG_ZERO)
                   & (hit_rs1 | hit_rs2);

    // A miss overrides everything; a flush squashes the stalled consumer.
    assign stall_ifid = reset & (dcache_stall | (~flush & luse));
    assign miss_inc   = reset & dcache_stall;
    assign luse_inc   = reset & ~dcache_stall & ~flush & luse;

    always_ff @(posedge clock) begin
        if (!reset) begin
            idex  <= BUBBLE;
            exmem <= BUBBLE;
            memwb <= BUBBLE;
        end else if (!dcache_stall) begin
            exmem <= idex;
            memwb <= exmem;
            if (flush || luse) begin
                idex <= BUBBLE;
            end else begin
                idex <= capture(id_rd, id_regwrite, id_memread);
            end
        end
    end

    assign idex_rd        = idex.rd;
    assign idex_regwrite  = idex.regwrite;
    assign idex_memread   = idex.memread;
    assign exmem_rd       = exmem.rd;
    assign exmem_regwrite = exmem.regwrite;
    assign memwb_rd       = memwb.rd;
    assign memwb_regwrite = memwb.regwrite;

    ctrl_sat_counter #(.CNT_W(CNT_W)) u_luse_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (luse_inc),
        .count (luse_cnt)
    );

    ctrl_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: doc/control_dest_tracker.md
Name: control_dest_tracker

Overview:
- Producer side of the EX-stage forwarding interface: carries each instruction's destination register, regwrite and memread from ID through EX, MEM and WB.
- Drives the exmem_rd, memwb_rd, exmem_regwrite and memwb_regwrite signals consumed by the bypass detector.
- Detects load-use hazards and applies the pipeline freeze during data-cache misses.
- Counts hazard and miss stall cycles for performance reporting.

Parameters:
CNT_W, 32, width of each saturating performance counter

Ports:
clock  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-low; 0 at a rising edge clears all state
ifid_rs1  input  5  rs1 of the instruction in ID
ifid_rs2  input  5  rs2 of the instruction in ID
ifid_use_rs1  input  1  ID instruction reads rs1
ifid_use_rs2  input  1  ID instruction reads rs2
id_rd  input  5  destination of the ID instruction
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
flush  input  1  branch/jump redirect resolved in EX; squash the ID instruction
dcache_stall  input  1  data cache miss pending in MEM; freeze the pipeline
stall_ifid  output  1  hold the PC and the IF/ID register (combinational)
idex_rd  output  5  EX-stage destination
idex_regwrite  output  1  EX-stage regwrite
idex_memread  output  1  EX-stage load flag
exmem_rd  output  5  MEM-stage destination, to bypass control
exmem_regwrite  output  1  MEM-stage regwrite, to bypass control
memwb_rd  output  5  WB-stage destination, to bypass control
memwb_regwrite  output  1  WB-stage regwrite, to bypass control
luse_cnt  output  CNT_W  load-use stall cycles
miss_cnt  output  CNT_W  dcache-stall cycles

Behaviour:
- Reset (reset=0 at an edge): all rd fields, regwrite bits, memread bits and counters become 0.
- Normalisation on capture:
  - regwrite is stored as id_regwrite & (id_rd != 0).
  - memread is stored as id_memread.
  - Result: exmem_regwrite and memwb_regwrite are never 1 with rd = 0.
- Load-use hazard (luse):
  - luse = idex_memread & idex_rd != 0 & ((ifid_use_rs1 & ifid_rs1 == idex_rd) | (ifid_use_rs2 & ifid_rs2 == idex_rd)).
- Per-cycle priority, highest first:
  1. dcache_stall=1: idex, exmem and memwb hold their values; stall_ifid=1; miss_cnt+1. flush and luse are ignored this cycle.
  2. flush=1: idex loads a bubble (rd=0, regwrite=0, memread=0); exmem<=idex; memwb<=exmem; stall_ifid=0, even if luse=1, because the ID instruction is squashed; luse_cnt is not incremented.
  3. luse=1: stall_ifid=1; idex loads a bubble; exmem<=idex; memwb<=exmem; luse_cnt+1.
  4. Otherwise: idex<=ID fields; exmem<=idex; memwb<=exmem; stall_ifid=0.
- stall_ifid is purely combinational from current state and inputs, with zero latency. It is 0 while reset=0.
- Latency: an ID instruction's rd appears on idex_rd one cycle later, on exmem_rd two cycles later and on memwb_rd three cycles later, plus any stall cycles.
- Load-use stalls exactly one cycle. After the bubble, the load is in MEM and the bypass path supplies the value from memwb on the next cycle.
- Back-to-back dependent loads each cause one stall.
- A miss arriving during a luse cycle (dcache_stall=1) takes priority. The luse then re-evaluates after the miss clears, since the state is frozen.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-miss or mid-stall: reset wins; next state is all zero.
- Branch-delay bubble: the instruction in EX at flush time proceeds normally. For example, jal's rd is kept.

Decomposition:
- Shared constants go in constants.v: register-index width (5), REG_ZERO, and a bubble constant for the {rd, regwrite, memread} triple.
- Natural sub-module: ctrl_sat_counter (CNT_W parameter, inc, clock, reset), instantiated twice.
- The stage registers and hazard logic stay in the top module.

Test Plan:
1. Independent ALU chain. id_rd=5, 6, 7 on consecutive cycles with regwrite=1 -> memwb_rd=5, 6, 7 on cycles 3, 4, 5; stall_ifid stays 0.
2. Load-use. lw x5 then add x1,x5,x2 (use_rs1=1, rs1=5) -> stall_ifid=1 for exactly one cycle; next idex_rd=0 and idex_regwrite=0; luse_cnt=1; after that, exmem_rd=5 while add is in ID again.
3. x0 destination. id_rd=0 with id_regwrite=1 -> exmem_regwrite=0 and memwb_regwrite=0 throughout; a load to x0 followed by a read of x0 does not stall.
4. Cache miss. dcache_stall=1 for 4 cycles with exmem_rd=9 and memwb_rd=3 -> both hold for all 4 cycles; stall_ifid=1; miss_cnt=4; pipeline resumes the cycle after.
5. flush together with luse -> stall_ifid=0; idex gets a bubble; luse_cnt unchanged. flush together with dcache_stall -> everything holds; miss_cnt+1.
6. Reset mid-miss. reset=0 while dcache_stall=1 and state is nonzero -> next cycle all outputs 0. Counter saturation: with CNT_W=4, 20 stall cycles -> miss_cnt=15.
